// File: rtl/host_ctrl.sv
// Host/test-control slave on the data-memory bus: captures the program's tohost
// completion write, reports pass/fail with an exit code and runs a cycle watchdog.
module host_ctrl #(
    parameter logic [31:0] host_addr = 32'h80001000,
    parameter logic [31:0] timeout   = 32'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        host_done,
    output logic        host_pass,
    output logic [30:0] host_code,
    output logic        host_timeout
);

    // Bus handshake: the master raises mem_valid and holds address, data and
    // strobes stable until it samples mem_ready=1 on a rising edge. The slave
    // accepts in IDLE, raises mem_ready for exactly the following cycle (RESP)
    // and never accepts while in RESP, so the held request is not taken twice.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] REG_TOHOST = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;

    state_t      state;
    logic [1:0]  reg_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] tohost_q;
    logic [31:0] cycle_q;

    logic sel;
    logic tohost_wr;
    logic complete;
    logic wd_fire;
    logic count_en;

    assign sel = mem_valid & ~mem_instr & (mem_addr[31:4] == host_addr[31:4]);

    always_comb begin
        tohost_wr = (state == RESP) && (reg_q == REG_TOHOST) && (wstrb_q == 4'b1111);
        complete  = tohost_wr && wdata_q[0] && !host_done;
        wd_fire   = (timeout != 32'd0) && (cycle_q == timeout - 32'd1) && !host_done;
        count_en  = !host_done && !host_timeout && (cycle_q != 32'hFFFFFFFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            reg_q        <= 2'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            tohost_q     <= 32'd0;
            cycle_q      <= 32'd0;
            mem_ready    <= 1'b0;
            host_done    <= 1'b0;
            host_pass    <= 1'b0;
            host_code    <= 31'd0;
            host_timeout <= 1'b0;
        end else begin
            if (count_en) begin
                cycle_q <= cycle_q + 32'd1;
            end

            // A completing write on the expiry edge takes precedence over the watchdog.
            if (wd_fire && !complete) begin
                host_timeout <= 1'b1;
            end

            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (sel) begin
                        reg_q     <= mem_addr[3:2];
                        wdata_q   <= mem_wdata;
                        wstrb_q   <= mem_wstrb;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                    if (tohost_wr) begin
                        tohost_q <= wdata_q;
                    end
                    if (complete) begin
                        host_done <= 1'b1;
                        host_code <= wdata_q[31:1];
                        host_pass <= (wdata_q[31:1] == 31'd0);
                    end
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Read data reflects register contents during the acknowledge cycle of a read.
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_ready && (wstrb_q == 4'd0)) begin
            case (reg_q)
                REG_TOHOST: mem_rdata = tohost_q;
                REG_STATUS: mem_rdata = {28'd0, host_timeout, host_pass, host_done, 1'b1};
                REG_CYCLE:  mem_rdata = cycle_q;
                default:    mem_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_host_ctrl.sv
// Randomised scoreboard bench for host_ctrl with a behavioural model based on
// edge counts since reset release.
module tb_host_ctrl;

  localparam logic [31:0] HOST = 32'h80001000;
  localparam int TO = 20;
  localparam int NONE = 1 << 30;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        host_done;
  logic        host_pass;
  logic [30:0] host_code;
  logic        host_timeout;

  host_ctrl #(.host_addr(HOST), .timeout(TO)) dut (
    .clock(clock),
    .reset(reset),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .host_done(host_done),
    .host_pass(host_pass),
    .host_code(host_code),
    .host_timeout(host_timeout)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // reference model: completion edge d_edge, watchdog edge TO, counter = min(n, d, TO)
  int          d_edge;
  logic [30:0] code_m;
  logic        pass_m;
  logic [31:0] tohost_m;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];
  bit          chk_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_done(input int n);
    return d_edge <= n;
  endfunction

  function automatic logic exp_to(input int n);
    return (TO != 0) && (n >= TO) && !(d_edge <= TO);
  endfunction

  function automatic logic [31:0] exp_read(input int a, input logic [1:0] idx);
    int cnt;
    logic dn;
    dn = exp_done(a);
    cnt = a;
    if (d_edge < cnt) cnt = d_edge;
    if (TO != 0 && TO < cnt) cnt = TO;
    case (idx)
      2'd0: return tohost_m;
      2'd1: return {28'd0, exp_to(a), dn & pass_m, dn, 1'b1};
      2'd2: return cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input int e, input logic [1:0] idx, input logic [3:0] strb,
                             input logic [31:0] wd);
    if (idx == 2'd0 && strb == 4'b1111) begin
      tohost_m = wd;
      if (wd[0] && d_edge == NONE) begin
        d_edge = e;
        code_m = wd[31:1];
        pass_m = (wd[31:1] == 31'd0);
      end
    end
  endtask

  task automatic model_clear();
    d_edge = NONE;
    code_m = 31'd0;
    pass_m = 1'b0;
    tohost_m = 32'd0;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [31:0] e;
    bit k;
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {31'd0, mem_ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        k = chk_q.pop_front();
        if (k) check("rdata", mem_rdata, e);
      end
    end else begin
      check("rdata_idle", mem_rdata, 32'd0);
    end
    if (reset === 1'b0) begin
      check("flags", {29'd0, host_timeout, host_pass, host_done},
            {29'd0, exp_to(cyc), exp_done(cyc) & pass_m, exp_done(cyc)});
      check("code", {1'b0, host_code}, exp_done(cyc) ? {1'b0, code_m} : 32'd0);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'd0;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    int c;
    int n;
    @(negedge clock);
    c = cyc;
    if (strb == 4'd0) begin
      exp_q.push_back(exp_read(c + 1, addr[3:2]));
      chk_q.push_back(1'b1);
    end else begin
      exp_q.push_back(32'd0);
      chk_q.push_back(1'b0);
      model_write(c + 2, addr[3:2], strb, wd);
    end
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = strb;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (mem_ready !== 1'b1 && n < 8);
    check("ack_latency", n, 1);
    @(negedge clock);
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
  endtask

  task automatic hold_unselected(input logic [31:0] addr, input logic instr);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = 32'h1;
    mem_wstrb = 4'b1111;
    repeat (10) begin
      @(negedge clock);
      check("no_ack", {31'd0, mem_ready}, 32'd0);
    end
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'd0;
  endtask

  initial begin
    logic [31:0] wd;
    logic [31:0] addr;
    logic [3:0]  strb;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    model_clear();

    // reset state and CYCLE after 5 idle cycles
    do_reset();
    check("reset_outputs", {mem_ready, host_done, host_pass, host_timeout, 28'd0},
          32'd0);
    check("reset_code", {1'b0, host_code}, 32'd0);
    idle(4);
    xfer(HOST | 32'h8, 4'd0, 32'd0);

    // pass completion; later completion does not override
    do_reset();
    xfer(HOST, 4'b1111, 32'h00000001);
    xfer(HOST, 4'b1111, 32'h0000000B);
    xfer(HOST, 4'd0, 32'd0);
    xfer(HOST | 32'h4, 4'd0, 32'd0);

    // fail completion with code 21
    do_reset();
    xfer(HOST, 4'b1111, 32'h0000002B);
    xfer(HOST | 32'h4, 4'd0, 32'd0);
    xfer(HOST | 32'hC, 4'd0, 32'd0);

    // partial strobes change nothing
    do_reset();
    xfer(HOST, 4'b1111, 32'h00000010);
    xfer(HOST, 4'b0001, 32'h00000001);
    xfer(HOST, 4'd0, 32'd0);

    // watchdog expiry on the 20th edge
    do_reset();
    idle(19);
    check("timeout_before", {31'd0, host_timeout}, 32'd0);
    idle(1);
    check("timeout_at_20", {31'd0, host_timeout}, 32'd1);
    xfer(HOST | 32'h4, 4'd0, 32'd0);
    xfer(HOST | 32'h8, 4'd0, 32'd0);

    // completion acked on the expiry edge wins
    do_reset();
    idle(17);
    xfer(HOST, 4'b1111, 32'h00000001);
    check("tie_done", {31'd0, host_done}, 32'd1);
    check("tie_timeout", {31'd0, host_timeout}, 32'd0);
    idle(30);
    xfer(HOST | 32'h4, 4'd0, 32'd0);

    // unselected requests are never acknowledged
    do_reset();
    hold_unselected(HOST + 32'h10, 1'b0);
    hold_unselected(HOST, 1'b1);
    xfer(HOST | 32'h4, 4'd0, 32'd0);

    // reset during RESP discards the request
    do_reset();
    idle(3);
    @(negedge clock);
    exp_q.push_back(32'd0);
    chk_q.push_back(1'b0);
    mem_valid = 1'b1;
    mem_addr  = HOST;
    mem_wdata = 32'h1;
    mem_wstrb = 4'b1111;
    @(negedge clock);
    check("resp_before_reset", {31'd0, mem_ready}, 32'd1);
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    model_clear();
    @(negedge clock);
    check("reset_in_resp", {mem_ready, host_done, host_pass, host_timeout, 28'd0}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    xfer(HOST, 4'd0, 32'd0);

    // randomised episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      idle($urandom_range(0, 25));
      for (int k = 0; k < 16; k++) begin
        addr = HOST | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 1) == 0) begin
          xfer(addr, 4'd0, 32'd0);
        end else begin
          strb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 14)) : 4'b1111;
          wd = $urandom;
          if ($urandom_range(0, 3) == 0) wd = 32'h1;
          else if ($urandom_range(0, 2) != 0) wd[0] = 1'b0;
          xfer(addr, strb, wd);
        end
        idle($urandom_range(0, 3));
      end
    end

    idle(3);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
